// File: rtl/network_sweep_ctrl.sv
// rtl/network_sweep_ctrl.sv - sweep sequencer: issues network steps, filters results, hands updates downstream
module network_sweep_ctrl #(
    parameter int NEURON_ID_WIDTH = 8,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int ITER_WIDTH      = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [ITER_WIDTH-1:0]                     num_iter,
    input  logic [NEURON_ID_WIDTH:0]                  num_active,
    output logic                                      en_network,
    output logic                                      top_en_network,
    output logic [3:0]                                bits_in_active_neuron,
    input  logic                                      networkDone,
    input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_out,
    output logic                                      upd_valid,
    input  logic                                      upd_ready,
    output logic [NEURON_ID_WIDTH-1:0]                upd_id,
    output logic [TEN_DATA_WIDTH-1:0]                 upd_spike,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      cfg_err,
    output logic [ITER_WIDTH-1:0]                     iter_count,
    output logic [ITER_WIDTH-1:0]                     skip_count
);

    localparam int unsigned MAX_ACTIVE = 1 << NEURON_ID_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_FINISH
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [NEURON_ID_WIDTH:0]     active_q;
    logic [ITER_WIDTH-1:0]        iter_lim_q;
    logic [ITER_WIDTH-1:0]        iter_q;
    logic [ITER_WIDTH-1:0]        skip_q;
    logic [3:0]                   bits_q;
    logic [NEURON_ID_WIDTH-1:0]   id_q;
    logic [TEN_DATA_WIDTH-1:0]    spike_q;
    logic                         cfg_err_q;
    logic [NEURON_ID_WIDTH-1:0]   net_id;
    logic                         net_skip;
    logic                         cfg_ok;
    logic                         last_upd;

    // ceil(log2(n)) clamped to 3..8: the LFSR width the network needs to cover n neurons
    function automatic logic [3:0] range_bits(input logic [NEURON_ID_WIDTH:0] n);
        int c;
        c = 0;
        for (int i = 0; i <= NEURON_ID_WIDTH; i++) begin
            if ((32'd1 << i) < 32'(n)) c = i + 1;
        end
        if (c < 3) c = 3;
        if (c > 8) c = 8;
        return 4'(c);
    endfunction

    assign net_id   = spike_out[NEURON_ID_WIDTH-1:0];
    assign net_skip = {1'b0, net_id} >= active_q;
    assign cfg_ok   = (num_active != '0) && (32'(num_active) <= MAX_ACTIVE);
    assign last_upd = (iter_q + ITER_WIDTH'(1)) == iter_lim_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        en_network     = 1'b0;
        top_en_network = 1'b0;
        upd_valid      = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start && cfg_ok) state_d = (num_iter == '0) ? S_FINISH : S_ISSUE;
            end
            S_ISSUE: begin
                en_network     = 1'b1;
                top_en_network = 1'b1;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                top_en_network = 1'b1;
                if (networkDone) state_d = net_skip ? S_ISSUE : S_OUT;
            end
            S_OUT: begin
                upd_valid = 1'b1;
                if (upd_ready) state_d = last_upd ? S_FINISH : S_ISSUE;
            end
            S_FINISH: begin
                done    = !abort;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // abort wins over any handshake seen in the same cycle
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= '0;
            iter_lim_q <= '0;
            iter_q     <= '0;
            skip_q     <= '0;
            bits_q     <= 4'd8;
            id_q       <= '0;
            spike_q    <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            active_q   <= num_active;
                            iter_lim_q <= num_iter;
                            bits_q     <= range_bits(num_active);
                            iter_q     <= '0;
                            skip_q     <= '0;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!abort && networkDone) begin
                        id_q    <= net_id;
                        spike_q <= spike_out[TEN_DATA_WIDTH+NEURON_ID_WIDTH-1 -: TEN_DATA_WIDTH];
                        if (net_skip && skip_q != '1) skip_q <= skip_q + ITER_WIDTH'(1);
                    end
                end
                S_OUT: begin
                    if (!abort && upd_ready) iter_q <= iter_q + ITER_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign bits_in_active_neuron = bits_q;
    assign upd_id                = id_q;
    assign upd_spike             = spike_q;
    assign cfg_err               = cfg_err_q;
    assign iter_count            = iter_q;
    assign skip_count            = skip_q;

endmodule

// File: tb/tb_network_sweep_ctrl.sv
// tb/tb_network_sweep_ctrl.sv - randomized bench for network_sweep_ctrl with a transaction-level model
module tb_network_sweep_ctrl;

    localparam int NW = 8;
    localparam int TW = 2;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [IW-1:0]     num_iter = '0;
    logic [NW:0]       num_active = 9'd1;
    logic              en_network;
    logic              top_en_network;
    logic [3:0]        bits_in_active_neuron;
    logic              networkDone = 1'b0;
    logic [TW+NW-1:0]  spike_out = '0;
    logic              upd_valid;
    logic              upd_ready = 1'b0;
    logic [NW-1:0]     upd_id;
    logic [TW-1:0]     upd_spike;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [IW-1:0]     iter_count;
    logic [IW-1:0]     skip_count;

    network_sweep_ctrl #(
        .NEURON_ID_WIDTH(NW),
        .TEN_DATA_WIDTH (TW),
        .ITER_WIDTH     (IW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .abort                (abort),
        .num_iter             (num_iter),
        .num_active           (num_active),
        .en_network           (en_network),
        .top_en_network       (top_en_network),
        .bits_in_active_neuron(bits_in_active_neuron),
        .networkDone          (networkDone),
        .spike_out            (spike_out),
        .upd_valid            (upd_valid),
        .upd_ready            (upd_ready),
        .upd_id               (upd_id),
        .upd_spike            (upd_spike),
        .busy                 (busy),
        .done                 (done),
        .cfg_err              (cfg_err),
        .iter_count           (iter_count),
        .skip_count           (skip_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_bits(input int n);
        if (n <= 8)   return 3;
        if (n <= 16)  return 4;
        if (n <= 32)  return 5;
        if (n <= 64)  return 6;
        if (n <= 128) return 7;
        return 8;
    endfunction

    // network model: answers each issue pulse after 1..lat_max cycles, frozen when top_en drops
    int   lat_max = 1;
    bit   wide_ids = 1'b0;
    int   force_q[$];
    int   ncnt = 0;
    logic saw_issue = 1'b0;
    logic top_s = 1'b0;

    always @(negedge clk) begin
        saw_issue = en_network;
        top_s     = top_en_network;
    end

    always @(posedge clk) begin
        int id;
        int hi;
        logic [TW-1:0] sp;
        #1;
        networkDone = 1'b0;
        if (!top_s) ncnt = 0;
        if (saw_issue) ncnt = $urandom_range(1, lat_max);
        if (ncnt > 0) begin
            ncnt--;
            if (ncnt == 0) begin
                if (force_q.size() > 0) begin
                    id = force_q.pop_front();
                end else begin
                    hi = wide_ids ? 255 : int'(num_active) + 1;
                    if (hi > 255) hi = 255;
                    id = $urandom_range(0, hi);
                end
                sp          = TW'($urandom);
                spike_out   = {sp, NW'(id)};
                networkDone = 1'b1;
            end
        end
    end

    // reference model: predicts next-cycle outputs from this cycle's inputs
    bit m_busy = 0, m_res = 0, m_done = 0, m_cfg = 0, m_issue = 0;
    int m_bits = 8, m_iter = 0, m_skip = 0, m_lim_a = 0, m_lim_i = 0, m_id = 0, m_sp = 0;
    int start_cyc = 0, done_cyc = -1;
    int acc_cyc[$];
    int acc_id[$];

    always @(negedge clk) begin
        bit d_now;
        bit i_now;
        int id;
        if (cyc >= 1) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done && !abort);
            chk("cfg_err", cfg_err, m_cfg);
            chk("en_network", en_network, m_issue);
            chk("top_en_network", top_en_network, m_busy && !m_res && !m_done);
            chk("upd_valid", upd_valid, m_res);
            if (m_res) begin
                chk("upd_id", upd_id, m_id);
                chk("upd_spike", upd_spike, m_sp);
            end
            chk("bits", bits_in_active_neuron, m_bits);
            chk("iter_count", iter_count, m_iter);
            chk("skip_count", skip_count, m_skip);
        end
        if (upd_valid && upd_ready && !abort && !reset) begin
            acc_cyc.push_back(cyc);
            acc_id.push_back(int'(upd_id));
        end
        if (done) done_cyc = cyc;
        if (!m_busy && start && !reset) start_cyc = cyc;

        d_now = m_done;
        i_now = m_issue;
        if (reset) begin
            m_busy = 0; m_res = 0; m_done = 0; m_cfg = 0; m_issue = 0;
            m_bits = 8; m_iter = 0; m_skip = 0;
        end else begin
            m_done = 0; m_cfg = 0; m_issue = 0;
            if (!m_busy) begin
                if (start) begin
                    if (num_active >= 1 && num_active <= 256) begin
                        m_busy  = 1;
                        m_lim_a = int'(num_active);
                        m_lim_i = int'(num_iter);
                        m_bits  = exp_bits(int'(num_active));
                        m_iter  = 0;
                        m_skip  = 0;
                        m_res   = 0;
                        if (num_iter == 0) m_done = 1;
                        else               m_issue = 1;
                    end else begin
                        m_cfg = 1;
                    end
                end
            end else if (abort) begin
                m_busy = 0;
                m_res  = 0;
            end else if (d_now) begin
                m_busy = 0;
            end else if (m_res) begin
                if (upd_ready) begin
                    m_res = 0;
                    m_iter++;
                    if (m_iter == m_lim_i) m_done = 1;
                    else                   m_issue = 1;
                end
            end else if (!i_now && networkDone) begin
                id = int'(spike_out[NW-1:0]);
                if (id >= m_lim_a) begin
                    if (m_skip < (1 << IW) - 1) m_skip++;
                    m_issue = 1;
                end else begin
                    m_res = 1;
                    m_id  = id;
                    m_sp  = int'(spike_out[TW+NW-1:NW]);
                end
            end
        end
    end

    task automatic do_start(input int a, input int n);
        @(posedge clk); #1;
        num_active = (NW+1)'(a);
        num_iter   = IW'(n);
        start      = 1'b1;
        abort      = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int i;
        i = 0;
        while (busy && i < 400) begin
            @(posedge clk); #1;
            if (rnd) begin
                upd_ready = 1'($urandom_range(0, 1));
                abort     = ($urandom_range(0, 39) == 0);
            end
            i++;
        end
        abort = 1'b0;
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!upd_valid && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        chk("valid_timeout", upd_valid, 1);
    endtask

    task automatic clear_logs();
        acc_cyc.delete();
        acc_id.delete();
        done_cyc = -1;
    endtask

    initial begin
        int held_id;
        int a;
        int r;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_bits", bits_in_active_neuron, 8);
        chk("reset_busy", busy, 0);
        chk("reset_outputs", {en_network, top_en_network, upd_valid, done, cfg_err}, 0);
        chk("reset_counts", {iter_count, skip_count}, 0);

        // basic sweep with a one-cycle network
        lat_max = 1; upd_ready = 1'b1; clear_logs();
        do_start(256, 4);
        wait_idle(0);
        chk("basic_bits", bits_in_active_neuron, 8);
        chk("basic_beats", acc_cyc.size(), 4);
        for (int i = 0; i < acc_cyc.size() && i < 4; i++)
            chk("basic_beat_cycle", acc_cyc[i] - start_cyc, 3 + 3 * i);
        chk("basic_done_cycle", done_cyc - start_cyc, 13);
        chk("basic_iter", iter_count, 4);

        // out-of-range id is skipped
        clear_logs();
        force_q = '{6, 2};
        do_start(5, 1);
        wait_idle(0);
        chk("skip_bits", bits_in_active_neuron, 3);
        chk("skip_count", skip_count, 1);
        chk("skip_beats", acc_id.size(), 1);
        if (acc_id.size() > 0) chk("skip_id", acc_id[0], 2);

        // backpressure holds the offer and freezes the network
        upd_ready = 1'b0;
        do_start(20, 2);
        wait_valid();
        held_id = int'(upd_id);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid", upd_valid, 1);
            chk("bp_id", upd_id, held_id);
            chk("bp_top_en", top_en_network, 0);
        end
        upd_ready = 1'b1;
        wait_idle(0);
        chk("bp_iter", iter_count, 2);
        chk("bp_bits", bits_in_active_neuron, 5);

        // rejected and empty starts
        do_start(0, 3);
        chk("rej0_cfg_err", cfg_err, 1);
        chk("rej0_busy", busy, 0);
        do_start(300, 3);
        chk("rej300_cfg_err", cfg_err, 1);
        chk("rej300_bits", bits_in_active_neuron, 5);
        do_start(10, 0);
        chk("zero_done", done, 1);
        @(posedge clk); #1;
        chk("zero_busy", busy, 0);
        chk("zero_iter", iter_count, 0);
        chk("zero_bits", bits_in_active_neuron, 4);

        // abort in OUT beats a simultaneous upd_ready
        upd_ready = 1'b1;
        do_start(256, 3);
        while (iter_count == 0 && busy) begin @(posedge clk); #1; end
        upd_ready = 1'b0;
        wait_valid();
        abort = 1'b1; upd_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; upd_ready = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_iter", iter_count, 1);
        chk("abort_valid", upd_valid, 0);
        chk("abort_done", done, 0);

        // reset while waiting on the network
        lat_max = 3;
        do_start(100, 3);
        @(posedge clk); #1;
        chk("wait_top_en", top_en_network, 1);
        chk("wait_en", en_network, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_bits", bits_in_active_neuron, 8);
        chk("rst_outputs", {en_network, top_en_network, upd_valid, busy, done, cfg_err}, 0);
        chk("rst_data", {upd_id, upd_spike, iter_count, skip_count}, 0);

        // skip_count saturates
        lat_max = 1; upd_ready = 1'b1;
        for (int i = 0; i < 17; i++) force_q.push_back($urandom_range(1, 255));
        force_q.push_back(0);
        do_start(1, 1);
        wait_idle(0);
        chk("sat_skip", skip_count, 15);
        chk("sat_iter", iter_count, 1);

        // randomized sweeps with backpressure, latency and aborts
        lat_max = 3;
        for (int t = 0; t < 40; t++) begin
            wide_ids = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      a = 0;
            else if (r == 1) a = $urandom_range(257, 511);
            else             a = $urandom_range(1, 256);
            upd_ready = 1'($urandom_range(0, 1));
            do_start(a, $urandom_range(0, 6));
            wait_idle(1);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
